key_capture_slave: RTL and testbench

KEY_CAPTURE_SLAVE -- requirements
Module: key_capture_slave

---
 rtl/key_capture_pkg.sv | 29 ++
 rtl/key_debounce.sv | 57 +++++
 rtl/key_capture_slave.sv | 110 +++++++++++
 tb/tb_key_capture_slave.sv | 207 ++++++++++++++++++++
 4 files changed

// File: rtl/key_capture_pkg.sv
// Register map and small helpers shared by the key capture slave and its debouncers.
package key_capture_pkg;

  typedef enum logic [1:0] {
    KEY_REG_DATA  = 2'd0,
    KEY_REG_EDGE  = 2'd1,
    KEY_REG_MASK  = 2'd2,
    KEY_REG_COUNT = 2'd3
  } key_reg_e;

  localparam int unsigned KEY_BUS_W = 32;
  localparam int unsigned KEY_CNT_W = 8;
  localparam int unsigned KEY_MAX   = 8;

  // A one-cycle debounce still needs a one-bit counter to keep the vector legal.
  function automatic int unsigned db_cnt_width(input int unsigned cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

  function automatic logic [KEY_CNT_W-1:0] popcount8(input logic [KEY_MAX-1:0] v);
    logic [KEY_CNT_W-1:0] n;
    n = '0;
    for (int i = 0; i < KEY_MAX; i++) begin
      n = n + KEY_CNT_W'(v[i]);
    end
    return n;
  endfunction

endpackage

// File: rtl/key_debounce.sv
// One push-button: two-flop synchronizer then a stability counter.
// Debounced output follows a stable input 2 + DEBOUNCE_CYCLES cycles later; no backpressure.
module key_debounce
  import key_capture_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic key_i,
  output logic state_o
);

  localparam int unsigned CW = db_cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          sync1_q;
  logic          sync2_q;
  logic          state_q;
  logic          state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          differ;

  // The counter measures how many consecutive cycles the synchronized input
  // has disagreed with the accepted state; any agreement restarts it.
  always_comb begin
    differ  = sync2_q ^ state_q;
    state_d = state_q;
    cnt_d   = '0;
    if (differ) begin
      if (cnt_q == CNT_LAST) begin
        state_d = sync2_q;
        cnt_d   = cnt_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= 1'b1;
      cnt_q   <= '0;
    end else begin
      sync1_q <= key_i;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o = state_q;

endmodule

// File: rtl/key_capture_slave.sv
// Avalon-MM push-button slave: debounced state, press edge capture, press counter, masked irq.
// Readdata one cycle after read, irq one cycle after edge capture; zero wait states, no backpressure.
module key_capture_slave
  import key_capture_pkg::*;
#(
  parameter int NUM_KEYS        = 3,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_KEYS-1:0] key_in,
  input  logic [1:0]          address,
  input  logic                read,
  input  logic                write,
  input  logic [31:0]         writedata,
  output logic [31:0]         readdata,
  output logic                irq
);

  logic [NUM_KEYS-1:0]  db_state;
  logic [NUM_KEYS-1:0]  db_prev_q;
  logic [NUM_KEYS-1:0]  press;
  logic [KEY_MAX-1:0]   press_w;
  logic [NUM_KEYS-1:0]  edge_q;
  logic [NUM_KEYS-1:0]  edge_d;
  logic [NUM_KEYS-1:0]  mask_q;
  logic [NUM_KEYS-1:0]  mask_d;
  logic [KEY_CNT_W-1:0] count_q;
  logic [KEY_CNT_W-1:0] count_d;
  logic [KEY_BUS_W-1:0] rdata_q;
  logic [KEY_BUS_W-1:0] rdata_d;
  logic                 irq_q;
  logic                 irq_d;
  logic                 wr_edge;
  logic                 wr_mask;
  logic                 wr_count;
  logic                 unused_wdata;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk_i  (clk),
      .reset_i(reset),
      .key_i  (key_in[k]),
      .state_o(db_state[k])
    );
  end

  // Keys are active-low, so a press is a debounced 1 -> 0 transition.
  assign press    = db_prev_q & ~db_state;
  assign wr_edge  = write && (address == KEY_REG_EDGE);
  assign wr_mask  = write && (address == KEY_REG_MASK);
  assign wr_count = write && (address == KEY_REG_COUNT);

  assign unused_wdata = ^writedata[KEY_BUS_W-1:NUM_KEYS];

  always_comb begin
    press_w                = '0;
    press_w[NUM_KEYS-1:0]  = press;

    // A fresh press wins over a W1C on the same bit, and over a counter clear.
    edge_d = edge_q;
    if (wr_edge) begin
      edge_d = edge_q & ~writedata[NUM_KEYS-1:0];
    end
    edge_d = edge_d | press;

    mask_d = wr_mask ? writedata[NUM_KEYS-1:0] : mask_q;

    count_d = (wr_count ? '0 : count_q) + popcount8(press_w);

    irq_d = |(edge_q & mask_q);

    // Sampled from current register values, so a same-cycle write is not yet visible.
    rdata_d = rdata_q;
    if (read) begin
      rdata_d = '0;
      case (key_reg_e'(address))
        KEY_REG_DATA:  rdata_d[NUM_KEYS-1:0]  = ~db_state;
        KEY_REG_EDGE:  rdata_d[NUM_KEYS-1:0]  = edge_q;
        KEY_REG_MASK:  rdata_d[NUM_KEYS-1:0]  = mask_q;
        KEY_REG_COUNT: rdata_d[KEY_CNT_W-1:0] = count_q;
        default:       rdata_d                = '0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      db_prev_q <= '1;
      edge_q    <= '0;
      mask_q    <= '0;
      count_q   <= '0;
      rdata_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      db_prev_q <= db_state;
      edge_q    <= edge_d;
      mask_q    <= mask_d;
      count_q   <= count_d;
      rdata_q   <= rdata_d;
      irq_q     <= irq_d;
    end
  end

  assign readdata = rdata_q;
  assign irq      = irq_q;

endmodule

// File: tb/tb_key_capture_slave.sv
// Directed bench for key_capture_slave with a short debounce window.
module tb_key_capture_slave;
  import key_capture_pkg::*;

  localparam int NK = 3;
  localparam int DB = 8;

  logic          clk = 1'b0;
  logic          reset;
  logic [NK-1:0] key_in;
  logic [1:0]    address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [31:0]   readdata;
  logic          irq;

  int n_vec  = 0;
  int n_miss = 0;

  always #5 clk = ~clk;

  key_capture_slave #(
    .NUM_KEYS       (NK),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .key_in   (key_in),
    .address  (address),
    .read     (read),
    .write    (write),
    .writedata(writedata),
    .readdata (readdata),
    .irq      (irq)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, want %h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    address = a;
    read    = 1'b1;
    tick(1);
    read    = 1'b0;
    d       = readdata;
  endtask

  task automatic expect_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    logic [31:0] d;
    bus_read(a, d);
    chk(tag, d, exp);
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write     = 1'b1;
    tick(1);
    write     = 1'b0;
  endtask

  task automatic press_release(input int k);
    key_in[k] = 1'b0;
    tick(12);
    key_in[k] = 1'b1;
    tick(12);
  endtask

  initial begin
    reset = 1'b1; read = 1'b0; write = 1'b0;
    key_in = '1; address = 2'd0; writedata = 32'd0;
    tick(3);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_irq", {31'b0, irq}, 32'd0);
    reset = 1'b0;
    tick(2);
    expect_reg("rst_data",  KEY_REG_DATA,  32'd0);
    expect_reg("rst_edge",  KEY_REG_EDGE,  32'd0);
    expect_reg("rst_mask",  KEY_REG_MASK,  32'd0);
    expect_reg("rst_count", KEY_REG_COUNT, 32'd0);

    // Key 0 pressed right after edge E0: debounced at E0+10, captured at E0+11.
    key_in[0] = 1'b0;
    address   = KEY_REG_DATA;
    read      = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 10) chk("press_lat_early", readdata, 32'd0);
      if (k == 11) begin
        chk("press_lat_exact", readdata, 32'd1);
        address = KEY_REG_EDGE;
      end
      if (k == 12) chk("edge_set", readdata, 32'd1);
    end
    read = 1'b0;
    expect_reg("count_first", KEY_REG_COUNT, 32'd1);
    tick(3);
    chk("rd_hold", readdata, 32'd1);
    chk("irq_masked", {31'b0, irq}, 32'd0);

    bus_write(KEY_REG_EDGE, 32'h1);
    expect_reg("w1c_edge", KEY_REG_EDGE, 32'd0);

    // Five-cycle glitch on key 1.
    key_in[1] = 1'b0;
    tick(5);
    key_in[1] = 1'b1;
    tick(20);
    expect_reg("glitch_data",  KEY_REG_DATA,  32'd1);
    expect_reg("glitch_edge",  KEY_REG_EDGE,  32'd0);
    expect_reg("glitch_count", KEY_REG_COUNT, 32'd1);

    key_in[0] = 1'b1;
    tick(15);
    expect_reg("release_data",  KEY_REG_DATA,  32'd0);
    expect_reg("release_edge",  KEY_REG_EDGE,  32'd0);
    expect_reg("release_count", KEY_REG_COUNT, 32'd1);

    // Masked interrupt on key 2; upper writedata bits must be dropped.
    bus_write(KEY_REG_MASK, 32'hFFFF_FFFC);
    expect_reg("mask_load", KEY_REG_MASK, 32'd4);
    key_in[2] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick(1);
      if (k == 11) chk("irq_before", {31'b0, irq}, 32'd0);
      if (k == 12) chk("irq_set", {31'b0, irq}, 32'd1);
    end
    expect_reg("edge_key2", KEY_REG_EDGE, 32'd4);
    bus_write(KEY_REG_EDGE, 32'h4);
    chk("irq_hold", {31'b0, irq}, 32'd1);
    tick(1);
    chk("irq_clr", {31'b0, irq}, 32'd0);
    key_in[2] = 1'b1;
    tick(15);
    expect_reg("count_two", KEY_REG_COUNT, 32'd2);

    // W1C landing on the same edge as a key 0 press event.
    key_in[0] = 1'b0;
    tick(10);
    bus_write(KEY_REG_EDGE, 32'h1);
    expect_reg("w1c_vs_press", KEY_REG_EDGE, 32'd1);
    expect_reg("count_three", KEY_REG_COUNT, 32'd3);

    // Counter clear landing on the same edge as a press event.
    key_in[0] = 1'b1;
    tick(15);
    key_in[0] = 1'b0;
    tick(10);
    bus_write(KEY_REG_COUNT, 32'd0);
    expect_reg("clr_vs_press", KEY_REG_COUNT, 32'd1);
    key_in[0] = 1'b1;
    tick(15);

    // Read and write of the mask in the same cycle.
    address   = KEY_REG_MASK;
    writedata = 32'h1;
    read      = 1'b1;
    write     = 1'b1;
    tick(1);
    read  = 1'b0;
    write = 1'b0;
    chk("rw_same_old", readdata, 32'd4);
    expect_reg("rw_same_new", KEY_REG_MASK, 32'd1);

    bus_write(KEY_REG_COUNT, 32'hDEAD_BEEF);
    expect_reg("count_clear", KEY_REG_COUNT, 32'd0);
    for (int i = 0; i < 256; i++) press_release(0);
    expect_reg("count_wrap", KEY_REG_COUNT, 32'd0);
    press_release(0);
    expect_reg("count_after_wrap", KEY_REG_COUNT, 32'd1);
    chk("irq_mask0", {31'b0, irq}, 32'd1);

    // Reset in the middle of a key 1 debounce, key held low throughout.
    key_in[1] = 1'b0;
    tick(5);
    reset = 1'b1;
    tick(2);
    chk("rst2_readdata", readdata, 32'd0);
    chk("rst2_irq", {31'b0, irq}, 32'd0);
    address = KEY_REG_DATA;
    read    = 1'b1;
    reset   = 1'b0;
    for (int k = 1; k <= 11; k++) begin
      tick(1);
      if (k == 10) chk("rst2_lat_early", readdata, 32'd0);
      if (k == 11) chk("rst2_lat_exact", readdata, 32'd2);
    end
    read = 1'b0;
    expect_reg("rst2_mask", KEY_REG_MASK, 32'd0);
    expect_reg("rst2_count", KEY_REG_COUNT, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
